// File: rtl/cam_slot_manager_pkg.sv
// Shared definitions for the CAM slot manager: response status codes,
// request op codes and the control FSM state encoding.
package cam_slot_manager_pkg;

  localparam logic [1:0] STATUS_OK           = 2'd0;
  localparam logic [1:0] STATUS_FULL         = 2'd1;
  localparam logic [1:0] STATUS_NOT_OCCUPIED = 2'd2;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [2:0] STATE_IDLE      = 3'd0;
  localparam logic [2:0] STATE_ISSUE     = 3'd1;
  localparam logic [2:0] STATE_WAIT_BUSY = 3'd2;
  localparam logic [2:0] STATE_WAIT_DONE = 3'd3;
  localparam logic [2:0] STATE_RESP      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = STATE_IDLE,
    ST_ISSUE     = STATE_ISSUE,
    ST_WAIT_BUSY = STATE_WAIT_BUSY,
    ST_WAIT_DONE = STATE_WAIT_DONE,
    ST_RESP      = STATE_RESP
  } state_t;

endpackage

// File: rtl/cam_slot_manager_if.sv
// Request/response handshake bundle for the CAM slot manager.
//   master : requester side (drives req_*, resp_ready)
//   slave  : slot manager side (drives req_ready, resp_*)
interface cam_slot_manager_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [DATA_WIDTH-1:0] req_data;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [1:0]            resp_status;

  modport master (
    output req_valid, req_op, req_data, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_status
  );

  modport slave (
    input  req_valid, req_op, req_data, req_addr, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_status
  );
endinterface

// File: rtl/priority_encoder.sv
// Combinational priority encoder.
//   input_unencoded : request vector
//   output_valid    : any bit set
//   output_encoded  : index of the winning bit; with LSB_PRIORITY "HIGH"
//                     the lowest set index wins, otherwise the highest.
module priority_encoder #(
  parameter int WIDTH        = 4,
  parameter     LSB_PRIORITY = "HIGH"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);
  localparam int ENC_W = $clog2(WIDTH);

  assign output_valid = |input_unencoded;

  generate
    if (LSB_PRIORITY == "HIGH") begin : g_lsb
      // Scan downwards so the last (lowest) hit wins.
      always_comb begin
        output_encoded = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (input_unencoded[i]) output_encoded = ENC_W'(i);
        end
      end
    end else begin : g_msb
      always_comb begin
        output_encoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (input_unencoded[i]) output_encoded = ENC_W'(i);
        end
      end
    end
  endgenerate
endmodule

// File: rtl/cam_slot_manager.sv
// CAM slot manager: accepts insert/delete requests, allocates the lowest
// free CAM slot for inserts, drives the CAM write port and returns a
// response with the slot address and a status code.
//   clk, rst         : clock, synchronous active-high reset (shared with CAM)
//   req_if           : request/response handshake (slave side)
//   cam_write_*      : registered CAM write port; cam_write_busy from CAM
//   occupancy        : number of occupied slots
//   full, empty      : derived from occupancy
module cam_slot_manager
  import cam_slot_manager_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_slot_manager_if.slave     req_if,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  empty
);
  localparam int                SLOTS     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SLOTS_CNT = (ADDR_WIDTH + 1)'(SLOTS);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);

  state_t                  state;
  logic [SLOTS-1:0]        bitmap;
  logic                    free_valid;
  logic [ADDR_WIDTH-1:0]   free_idx;
  logic                    accept;

  priority_encoder #(
    .WIDTH        (SLOTS),
    .LSB_PRIORITY ("HIGH")
  ) u_free_finder (
    .input_unencoded (~bitmap),
    .output_valid    (free_valid),
    .output_encoded  (free_idx)
  );

  assign req_if.req_ready = (state == ST_IDLE) && !cam_write_busy;
  assign accept           = req_if.req_valid && req_if.req_ready;

  assign full  = (occupancy == SLOTS_CNT);
  assign empty = (occupancy == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      bitmap             <= '0;
      occupancy          <= '0;
      cam_write_addr     <= '0;
      cam_write_data     <= '0;
      cam_write_delete   <= 1'b0;
      cam_write_enable   <= 1'b0;
      req_if.resp_valid  <= 1'b0;
      req_if.resp_addr   <= '0;
      req_if.resp_status <= STATUS_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // No free slot from the finder is the same condition as full.
            if (req_if.req_op == OP_INSERT && !free_valid) begin
              req_if.resp_status <= STATUS_FULL;
              req_if.resp_addr   <= '0;
              req_if.resp_valid  <= 1'b1;
              state              <= ST_RESP;
            end else if (req_if.req_op == OP_DELETE && !bitmap[req_if.req_addr]) begin
              req_if.resp_status <= STATUS_NOT_OCCUPIED;
              req_if.resp_addr   <= req_if.req_addr;
              req_if.resp_valid  <= 1'b1;
              state              <= ST_RESP;
            end else begin
              // addr/data/delete stay put until the CAM reports completion.
              cam_write_addr   <= (req_if.req_op == OP_INSERT) ? free_idx : req_if.req_addr;
              cam_write_data   <= req_if.req_data;
              cam_write_delete <= req_if.req_op;
              cam_write_enable <= 1'b1;
              state            <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cam_write_enable <= 1'b0;
          state            <= ST_WAIT_BUSY;
        end
        // The CAM raises busy one cycle after sampling enable, so busy is
        // not meaningful yet here.
        ST_WAIT_BUSY: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (!cam_write_busy) begin
            if (cam_write_delete) begin
              bitmap[cam_write_addr] <= 1'b0;
              occupancy              <= occupancy - ONE_CNT;
            end else begin
              bitmap[cam_write_addr] <= 1'b1;
              occupancy              <= occupancy + ONE_CNT;
            end
            req_if.resp_addr   <= cam_write_addr;
            req_if.resp_status <= STATUS_OK;
            req_if.resp_valid  <= 1'b1;
            state              <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (req_if.resp_ready) begin
            req_if.resp_valid <= 1'b0;
            state             <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cam_slot_manager.md
Name: cam_slot_manager

Overview:
- Sits directly upstream of the BRAM CAM.
- Accepts insert/delete requests over a valid/ready handshake, keeps a free-slot bitmap, and allocates the lowest free CAM address for each insert.
- Drives the CAM write port (addr/data/delete/enable), waits for the CAM write to complete, then returns a response carrying the slot address and a status code.

Parameters:
- DATA_WIDTH, 64, key width; matches the CAM DATA_WIDTH.
- ADDR_WIDTH, 5, log2 of the CAM depth; the block manages 2**ADDR_WIDTH slots.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  1  0 = insert, 1 = delete
- req_data  in  DATA_WIDTH  key to insert; ignored for delete
- req_addr  in  ADDR_WIDTH  slot to delete; ignored for insert
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_addr  out  ADDR_WIDTH  allocated slot (insert) or freed slot (delete)
- resp_status  out  2  0 = OK, 1 = FULL, 2 = NOT_OCCUPIED
- cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
- cam_write_data  out  DATA_WIDTH  to CAM write_data
- cam_write_delete  out  1  to CAM write_delete
- cam_write_enable  out  1  to CAM write_enable
- cam_write_busy  in  1  from CAM write_busy; high during CAM init and during a write
- occupancy  out  ADDR_WIDTH+1  number of occupied slots
- full  out  1  occupancy == 2**ADDR_WIDTH
- empty  out  1  occupancy == 0

Behaviour:
- Reset values: all outputs 0 except empty = 1. Bitmap cleared, state IDLE.
- rst is shared with the CAM, so the CAM re-initialises at the same time. A reset mid-operation abandons any request and drops any pending response.
- req_ready = (state == IDLE) && !cam_write_busy. While the CAM initialises after reset, no request is accepted.
- All cam_write_* outputs are registered. addr, data and delete are held stable from ISSUE until the block leaves WAIT_DONE.
- cam_write_enable is high for exactly one cycle (ISSUE).
- States:
  - IDLE: on accept, latch op, data and addr, then check:
    - insert with full = 1: go to RESP, status FULL, resp_addr = 0, no CAM write.
    - delete with bitmap[req_addr] = 0: go to RESP, status NOT_OCCUPIED, resp_addr = req_addr, no CAM write.
    - insert otherwise: take the lowest free index (LSB priority) as the slot, go to ISSUE.
    - delete otherwise: slot = req_addr, go to ISSUE.
  - ISSUE: cam_write_enable = 1. cam_write_delete = 1 for delete, 0 for insert. Go to WAIT_BUSY.
  - WAIT_BUSY: one cycle; cam_write_busy is not checked. The CAM raises busy the cycle after it samples enable. Go to WAIT_DONE.
  - WAIT_DONE: stay while cam_write_busy = 1. When it is 0, update state and go to RESP:
    - insert: set bitmap[slot] and occupancy += 1.
    - delete: clear bitmap[slot] and occupancy -= 1.
  - RESP: resp_valid = 1 with addr and status held stable until resp_ready. On handshake, go to IDLE. resp_valid drops in the following cycle.
- Latency from the accept cycle T, with the standard CAM timing:
  - insert OK: resp_valid at T+7.
  - delete OK: resp_valid at T+5.
  - FULL / NOT_OCCUPIED: resp_valid at T+1.
- Only one request is in flight at a time; there is no overlap.
- Inserting a key already present in the CAM is not detected. The new slot is allocated and both slots will match.
- occupancy saturates neither way, because the checks above make overflow and underflow impossible.
- full and empty are derived combinationally from the registered occupancy.

Decomposition:
- Shared package holds:
  - the status codes STATUS_OK, STATUS_FULL, STATUS_NOT_OCCUPIED;
  - the op codes OP_INSERT, OP_DELETE;
  - the state encoding localparams.
- Sub-module: reuse the existing priority_encoder with WIDTH = 2**ADDR_WIDTH and LSB_PRIORITY "HIGH" on ~bitmap as the free-slot finder. Its output_valid low equals full.

Test Plan:
- Reset, hold cam_write_busy = 1 for 40 cycles, then 0 → req_ready stays 0 until busy falls; empty = 1, occupancy = 0.
- Three inserts of keys 0x11, 0x22, 0x33 against a CAM model → resp_addr 0, 1, 2 with status OK. Each shows exactly one cam_write_enable pulse with cam_write_delete = 0; occupancy = 3; each resp_valid arrives 7 cycles after accept.
- Delete slot 1, then insert 0x44 → delete returns OK, addr 1, cam_write_delete = 1, at T+5. The insert reuses addr 1.
- Delete slot 5 (unoccupied) → NOT_OCCUPIED, addr 5, at T+1, no cam_write_enable pulse.
- Fill all 32 slots, then insert once more → FULL, no CAM write; full = 1, occupancy = 32. With resp_ready held 0 for 10 cycles, resp_valid/addr/status stay stable and req_ready stays 0.
- Assert rst while in WAIT_DONE → next cycle all outputs are at reset values, the bitmap is empty, and the pending response never appears.
